// File: rtl/lfsr_word_ctrl_pkg.sv
// rtl/lfsr_word_ctrl_pkg.sv - shared state encoding and default sizes for the LFSR word sequencer
package lfsr_ctrl_pkg;

    localparam int DEF_DEGREE = 7;
    localparam int DEF_WORD_W = 8;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEED  = 3'd1,
        FLUSH = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } state_e;

endpackage

// File: rtl/lfsr_word_ctrl_if.sv
// rtl/lfsr_word_ctrl_if.sv - word stream handshake between sequencer (master) and consumer (slave)
interface lfsr_word_ctrl_if import lfsr_ctrl_pkg::*; #(
    parameter int WORD_W = DEF_WORD_W
);
    logic [WORD_W-1:0] Word_DO;
    logic              Valid_SO;
    logic              Ready_SI;

    modport master (output Word_DO, output Valid_SO, input Ready_SI);
    modport slave  (input Word_DO, input Valid_SO, output Ready_SI);
endinterface

// File: rtl/lfsr_bit_packer.sv
// rtl/lfsr_bit_packer.sv - serial-to-word shift register; first bit lands in the MSB
module lfsr_bit_packer #(
    parameter int WORD_W = 8
) (
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              bit_in,
    output logic [WORD_W-1:0] word,
    output logic              full
);
    localparam int CW = $clog2(WORD_W);
    localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);

    logic [WORD_W-1:0] word_q, word_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clr) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift_en) begin
            word_d = {word_q[WORD_W-2:0], bit_in};
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    // full flags the edge that captures the last bit of a word
    assign full = shift_en && (cnt_q == LAST);
    assign word = word_q;

endmodule

// File: rtl/lfsr_word_ctrl.sv
// rtl/lfsr_word_ctrl.sv - seeds/steps an external LFSR and delivers packed words over valid/ready
// Optional running ones count enabled by LFSR_WORD_CTRL_ONES_CNT_EN.
module lfsr_word_ctrl import lfsr_ctrl_pkg::*; #(
    parameter int               DEGREE       = DEF_DEGREE,
    parameter int               WORD_W       = DEF_WORD_W,
    parameter int               CNT_W        = DEF_CNT_W,
    parameter logic [DEGREE-1:0] DEFAULT_SEED = 'h01
) (
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    input  logic              Start_SI,
    input  logic              Stop_SI,
    input  logic [DEGREE-1:0] Seed_DI,
    input  logic [CNT_W-1:0]  NumWords_DI,
    output logic              Busy_SO,
    output logic              Done_SO,
    lfsr_word_ctrl_if.master  strm,
    output logic              LfsrWrEn_SO,
    output logic              LfsrSeedWr_SO,
    output logic [DEGREE-1:0] LfsrSeed_DO,
    input  logic              LfsrBit_DI
`ifdef LFSR_WORD_CTRL_ONES_CNT_EN
    ,
    output logic [CNT_W-1:0]  OnesCnt_DO
`endif
);
    state_e            state_q, state_d;
    logic [DEGREE-1:0] seed_q, seed_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              bounded_q, bounded_d;
    logic              done_q, done_d;

    logic start_acc, handshake, last_word, full;
    logic [WORD_W-1:0] word;

    assign start_acc = (state_q == IDLE) && Start_SI && !Stop_SI;
    assign handshake = (state_q == HOLD) && strm.Ready_SI;
    assign last_word = bounded_q && (remaining_q == CNT_W'(1));

    lfsr_bit_packer #(.WORD_W(WORD_W)) u_packer (
        .Clk_CI   (Clk_CI),
        .Rst_RBI  (Rst_RBI),
        .clr      (start_acc),
        .shift_en (state_q == SHIFT),
        .bit_in   (LfsrBit_DI),
        .word     (word),
        .full     (full)
    );

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q     <= IDLE;
            seed_q      <= '0;
            remaining_q <= '0;
            bounded_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            remaining_q <= remaining_d;
            bounded_q   <= bounded_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (Stop_SI && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start_acc) state_d = SEED;
                SEED:    state_d = FLUSH;
                FLUSH:   state_d = SHIFT;
                SHIFT:   if (full) state_d = HOLD;
                HOLD:    if (handshake) state_d = last_word ? IDLE : SHIFT;
                default: state_d = IDLE;
            endcase
        end
    end

    // Seed/counter capture and done pulse; an abort suppresses done.
    always_comb begin
        seed_d      = seed_q;
        remaining_d = remaining_q;
        bounded_d   = bounded_q;
        done_d      = 1'b0;
        if (start_acc) begin
            seed_d      = (Seed_DI == '0) ? DEFAULT_SEED : Seed_DI;
            remaining_d = NumWords_DI;
            bounded_d   = |NumWords_DI;
        end else if (handshake && !Stop_SI) begin
            done_d = last_word;
            if (bounded_q) remaining_d = remaining_q - CNT_W'(1);
        end
    end

    always_comb begin
        Busy_SO       = (state_q != IDLE);
        strm.Valid_SO = (state_q == HOLD);
        LfsrWrEn_SO   = (state_q == SEED) || (state_q == FLUSH) || (state_q == SHIFT);
        LfsrSeedWr_SO = (state_q == SEED);
    end

    assign Done_SO      = done_q;
    assign strm.Word_DO = word;
    assign LfsrSeed_DO  = seed_q;

`ifdef LFSR_WORD_CTRL_ONES_CNT_EN
    logic [CNT_W-1:0] ones_q, ones_d;

    always_comb begin
        ones_d = ones_q;
        if (start_acc)
            ones_d = '0;
        else if (state_q == SHIFT && LfsrBit_DI && ones_q != '1)
            ones_d = ones_q + CNT_W'(1);
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) ones_q <= '0;
        else          ones_q <= ones_d;
    end

    assign OnesCnt_DO = ones_q;
`endif

endmodule

// File: tb/tb_lfsr_word_ctrl.sv
// tb/tb_lfsr_word_ctrl.sv - directed self-checking bench with an x^7+x+1 LFSR datapath model
module tb_lfsr_word_ctrl;
    import lfsr_ctrl_pkg::*;

    localparam int DEGREE = 7;
    localparam int WORD_W = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, stop;
    logic [DEGREE-1:0] seed;
    logic [CNT_W-1:0]  num;
    logic              busy, done, wr_en, seed_wr;
    logic [DEGREE-1:0] lfsr_seed;
    logic              lfsr_bit = 1'b1;
    logic [DEGREE-1:0] lfsr_q   = 7'h5A;
`ifdef LFSR_WORD_CTRL_ONES_CNT_EN
    logic [CNT_W-1:0]  ones_cnt;
`endif

    lfsr_word_ctrl_if #(.WORD_W(WORD_W)) strm ();

    always #5 clk = ~clk;

    lfsr_word_ctrl #(
        .DEGREE(DEGREE), .WORD_W(WORD_W), .CNT_W(CNT_W), .DEFAULT_SEED(7'h01)
    ) dut (
        .Clk_CI        (clk),
        .Rst_RBI       (rst_n),
        .Start_SI      (start),
        .Stop_SI       (stop),
        .Seed_DI       (seed),
        .NumWords_DI   (num),
        .Busy_SO       (busy),
        .Done_SO       (done),
        .strm          (strm),
        .LfsrWrEn_SO   (wr_en),
        .LfsrSeedWr_SO (seed_wr),
        .LfsrSeed_DO   (lfsr_seed),
        .LfsrBit_DI    (lfsr_bit)
`ifdef LFSR_WORD_CTRL_ONES_CNT_EN
        ,
        .OnesCnt_DO    (ones_cnt)
`endif
    );

    // LFSR datapath: seed mux, x^7+x+1 step, registered output bit.
    always @(posedge clk) begin
        if (wr_en) begin
            lfsr_q   <= seed_wr ? lfsr_seed : {lfsr_q[0] ^ lfsr_q[1], lfsr_q[6:1]};
            lfsr_bit <= lfsr_q[0];
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] got_q[$];
    logic [6:0] gold_g;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gold_word(output logic [7:0] w);
        w = '0;
        for (int i = 0; i < 8; i++) begin
            w      = {w[6:0], gold_g[0]};
            gold_g = {gold_g[0] ^ gold_g[1], gold_g[6:1]};
        end
    endtask

    task automatic start_op(input logic [6:0] s, input logic [15:0] n);
        seed  = s;
        num   = n;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Observe-then-step; c is the number of edges since the call.
    task automatic collect(input int budget, output int fv, output int dones, output int ended);
        fv = -1; dones = 0; ended = 0;
        got_q.delete();
        for (int c = 0; c < budget; c++) begin
            if (strm.Valid_SO && fv < 0) fv = c;
            if (strm.Valid_SO && strm.Ready_SI) got_q.push_back(strm.Word_DO);
            if (done) dones++;
            if (!busy) begin
                ended = 1;
                break;
            end
            step();
        end
    endtask

    task automatic check_three(input string tag);
        check({tag, "_nwords"}, got_q.size(), 3);
        if (got_q.size() == 3) begin
            check({tag, "_w0"}, got_q[0], 8'h81);
            check({tag, "_w1"}, got_q[1], 8'h06);
            check({tag, "_w2"}, got_q[2], 8'h14);
        end
    endtask

    initial begin
        int fv, dones, ended, bad, nhs, c;
        logic [7:0] w;

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; seed = '0; num = '0;
        strm.Ready_SI = 1'b0;
        repeat (3) step();
        check("rst_busy",    busy, 0);
        check("rst_done",    done, 0);
        check("rst_valid",   strm.Valid_SO, 0);
        check("rst_wr_en",   wr_en, 0);
        check("rst_seed_wr", seed_wr, 0);
        check("rst_seed",    lfsr_seed, 0);
        check("rst_word",    strm.Word_DO, 0);
        rst_n = 1'b1;
        step();

        // Test 1: bounded run, ready tied high
        strm.Ready_SI = 1'b1;
        start_op(7'h01, 16'd3);
        check("t1_seed_wr", seed_wr, 1);
        check("t1_busy",    busy, 1);
        collect(200, fv, dones, ended);
        check("t1_latency", fv, 10);
        check_three("t1");
        check("t1_done_cnt", dones, 1);
        check("t1_ended",    ended, 1);
        step();
        check("t1_done_pulse", done, 0);

        // Test 2: zero seed substitutes default
        start_op(7'h00, 16'd3);
        check("t2_seed_out", lfsr_seed, 7'h01);
        check("t2_seed_wr",  seed_wr, 1);
        step();
        check("t2_flush_wr",  wr_en, 1);
        check("t2_flush_sel", seed_wr, 0);
        collect(200, fv, dones, ended);
        check_three("t2");
        check("t2_done_cnt", dones, 1);

        // Test 3: backpressure in HOLD
        strm.Ready_SI = 1'b0;
        start_op(7'h01, 16'd3);
        c = 0;
        while (!strm.Valid_SO && c < 50) begin
            step();
            c++;
        end
        check("t3_latency", c, 10);
        check("t3_word0",   strm.Word_DO, 8'h81);
        bad = 0;
        repeat (20) begin
            step();
            if (strm.Word_DO !== 8'h81 || wr_en !== 1'b0 || strm.Valid_SO !== 1'b1) bad++;
        end
        check("t3_hold_stable", bad, 0);
        strm.Ready_SI = 1'b1;
        collect(200, fv, dones, ended);
        check_three("t3");
        check("t3_done_cnt", dones, 1);

        // Test 4: unbounded stream, then abort while a word is pending
        start_op(7'h01, 16'd0);
        gold_g = 7'h01;
        bad = 0; nhs = 0; dones = 0;
        for (int k = 0; k < 4000; k++) begin
            if (strm.Valid_SO && strm.Ready_SI) begin
                gold_word(w);
                if (strm.Word_DO !== w) bad++;
                nhs++;
            end
            if (done) dones++;
            if (nhs == 305) break;
            step();
        end
        check("t4_handshakes", nhs, 305);
        check("t4_stream_err", bad, 0);
        check("t4_no_done",    dones, 0);
        check("t4_busy",       busy, 1);
        strm.Ready_SI = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t4_stop_busy",  busy, 0);
        check("t4_stop_valid", strm.Valid_SO, 0);
        check("t4_stop_wr_en", wr_en, 0);
        check("t4_stop_done",  done, 0);
        step();
        check("t4_stop_done2", done, 0);

        // Test 5: start ignored in SHIFT, stop in SEED, start+stop in IDLE
        strm.Ready_SI = 1'b1;
        start_op(7'h01, 16'd1);
        step();
        step();
        check("t5_shift_wr", wr_en, 1);
        seed = 7'h55; num = 16'd5; start = 1'b1;
        step();
        start = 1'b0;
        collect(200, fv, dones, ended);
        check("t5_latency", fv, 7);
        check("t5_nwords",  got_q.size(), 1);
        if (got_q.size() > 0) check("t5_w0", got_q[0], 8'h81);
        check("t5_done_cnt", dones, 1);
        start_op(7'h01, 16'd3);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t5_stop_busy",  busy, 0);
        check("t5_stop_wr_en", wr_en, 0);
        check("t5_stop_valid", strm.Valid_SO, 0);
        check("t5_stop_done",  done, 0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("t5_both_busy", busy, 0);

        // Test 6: asynchronous reset mid-SHIFT
        start_op(7'h01, 16'd3);
        repeat (5) step();
        check("t6_pre_wr_en", wr_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_busy",  busy, 0);
        check("t6_rst_wr_en", wr_en, 0);
        check("t6_rst_sel",   seed_wr, 0);
        check("t6_rst_valid", strm.Valid_SO, 0);
        check("t6_rst_word",  strm.Word_DO, 0);
        check("t6_rst_seed",  lfsr_seed, 0);
        check("t6_rst_done",  done, 0);
        step();
        rst_n = 1'b1;
        step();
        start_op(7'h01, 16'd3);
        collect(200, fv, dones, ended);
        check("t6_latency", fv, 10);
        check_three("t6");
        check("t6_done_cnt", dones, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
